// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART RX buffer.
// The pointer and count types are sized for the default depth.
package uart_fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  typedef logic [$clog2(FIFO_DEPTH_DEF)-1:0]   ptr_t;
  typedef logic [$clog2(FIFO_DEPTH_DEF+1)-1:0] cnt_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART RX stream, the register read path and the RX buffer.
// The slave modport is the buffer side. The master modport is the side that feeds and reads it.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  logic                           flush;
  logic [DATA_WIDTH-1:0]          s_axis_tdata;
  logic                           s_axis_tvalid;
  logic                           s_axis_tready;
  logic                           rd_en;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           rd_valid;
  logic                           full;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           overrun;
  logic                           clr_overrun;
  logic                           irq_en;
  logic                           irq;

  modport slave (
    input  flush, s_axis_tdata, s_axis_tvalid, rd_en, clr_overrun, irq_en,
    output s_axis_tready, rd_data, rd_valid, full, count, overrun, irq
  );

  modport master (
    output flush, s_axis_tdata, s_axis_tvalid, rd_en, clr_overrun, irq_en,
    input  s_axis_tready, rd_data, rd_valid, full, count, overrun, irq
  );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// Storage array for the RX buffer: one synchronous write port and one asynchronous read port.
// The asynchronous read port gives the buffer its first-word-fall-through head.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: a FWFT FIFO between the RX stream and the RX data register.
// It also provides the full, sticky overrun and level-interrupt status.
module uart_rx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] IRQ_CNT  = CNT_W'(IRQ_LEVEL);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overrun;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_tready;
  logic                  w_offer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_tready = !rst && !bus.flush;
  assign w_offer  = bus.s_axis_tvalid && w_tready;

  // A pop while full frees the slot the incoming byte lands in, so that byte is accepted.
  assign w_pop  = bus.rd_en && !w_empty && !bus.flush;
  assign w_push = w_offer && (!w_full || w_pop);
  assign w_drop = w_offer && w_full && !w_pop;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.s_axis_tdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overrun survives flush. A new drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                  r_overrun <= 1'b0;
    else if (w_drop)          r_overrun <= 1'b1;
    else if (bus.clr_overrun) r_overrun <= 1'b0;
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.rd_data       = w_empty ? '0 : w_head;
  assign bus.rd_valid      = !w_empty;
  assign bus.full          = w_full;
  assign bus.count         = r_count;
  assign bus.overrun       = r_overrun;
  assign bus.irq           = bus.irq_en && (r_count >= IRQ_CNT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: DEPTH=16, IRQ_LEVEL=4.
// Each scenario task drives its stimulus and checks outputs 1 ns after the clock edge.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .IRQ_LEVEL  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = b;
    tick();
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.s_axis_tvalid = 0; bus.s_axis_tdata = 0;
    bus.rd_en = 0; bus.clr_overrun = 0; bus.irq_en = 1;
    rst = 1;
    tick(); tick();
    n_total++;
    if (bus.s_axis_tready !== 1'b0) $display("FAIL reset_tready got=%0b exp=0", bus.s_axis_tready);
    else n_pass++;
    rst = 0;
    #1;
    n_total++;
    if ({bus.rd_valid, bus.full, bus.irq, bus.overrun, bus.s_axis_tready} !== 5'b00001)
      $display("FAIL reset_flags got=%b exp=00001",
               {bus.rd_valid, bus.full, bus.irq, bus.overrun, bus.s_axis_tready});
    else n_pass++;
    n_total++;
    if (bus.count !== 5'd0 || bus.rd_data !== 8'h00)
      $display("FAIL reset_data count=%0d rd_data=%h exp 0/00", bus.count, bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    push_byte(8'h41);
    n_total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h41)
      $display("FAIL latency rd_valid=%0b rd_data=%h exp 1/41", bus.rd_valid, bus.rd_data);
    else n_pass++;
    push_byte(8'h42);
    push_byte(8'h43);
    n_total++;
    if (bus.count !== 5'd3 || bus.rd_data !== 8'h41)
      $display("FAIL basic_fill count=%0d rd_data=%h exp 3/41", bus.count, bus.rd_data);
    else n_pass++;
    pop_one();
    n_total++;
    if (bus.rd_data !== 8'h42) $display("FAIL basic_pop1 got=%h exp=42", bus.rd_data);
    else n_pass++;
    pop_one();
    n_total++;
    if (bus.rd_data !== 8'h43) $display("FAIL basic_pop2 got=%h exp=43", bus.rd_data);
    else n_pass++;
    pop_one();
    n_total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.count !== 5'd0)
      $display("FAIL basic_empty rd_valid=%0b rd_data=%h count=%0d exp 0/00/0",
               bus.rd_valid, bus.rd_data, bus.count);
    else n_pass++;
  endtask

  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    n_total++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overrun !== 1'b0)
      $display("FAIL full_flag full=%0b count=%0d overrun=%0b exp 1/16/0",
               bus.full, bus.count, bus.overrun);
    else n_pass++;
    n_total++;
    if (bus.s_axis_tready !== 1'b1) $display("FAIL full_tready got=%0b exp=1", bus.s_axis_tready);
    else n_pass++;
    push_byte(8'hAA);
    n_total++;
    if (bus.overrun !== 1'b1 || bus.count !== 5'd16)
      $display("FAIL drop overrun=%0b count=%0d exp 1/16", bus.overrun, bus.count);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (bus.rd_data !== 8'(i)) $display("FAIL full_drain[%0d] got=%h exp=%h", i, bus.rd_data, 8'(i));
      else n_pass++;
      pop_one();
    end
    n_total++;
    if (bus.rd_valid !== 1'b0) $display("FAIL full_drain_empty got=%0b exp=0", bus.rd_valid);
    else n_pass++;
    bus.clr_overrun = 1; tick(); bus.clr_overrun = 0;
    n_total++;
    if (bus.overrun !== 1'b0) $display("FAIL clr_overrun got=%0b exp=0", bus.overrun);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus.s_axis_tvalid = 1; bus.s_axis_tdata = 8'h55; bus.rd_en = 1;
    tick();
    bus.s_axis_tvalid = 0; bus.rd_en = 0;
    n_total++;
    if (bus.overrun !== 1'b0 || bus.count !== 5'd16 || bus.rd_data !== 8'h01)
      $display("FAIL full_pushpop overrun=%0b count=%0d head=%h exp 0/16/01",
               bus.overrun, bus.count, bus.rd_data);
    else n_pass++;
    for (int i = 1; i < 17; i++) begin
      n_total++;
      if (bus.rd_data !== ((i == 16) ? 8'h55 : 8'(i)))
        $display("FAIL pushpop_drain[%0d] got=%h exp=%h", i, bus.rd_data,
                 (i == 16) ? 8'h55 : 8'(i));
      else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_irq();
    for (int i = 1; i <= 3; i++) begin
      push_byte(8'(i));
      n_total++;
      if (bus.irq !== 1'b0) $display("FAIL irq_below[%0d] got=%0b exp=0", i, bus.irq);
      else n_pass++;
    end
    push_byte(8'h04);
    n_total++;
    if (bus.irq !== 1'b1) $display("FAIL irq_level got=%0b exp=1", bus.irq);
    else n_pass++;
    bus.irq_en = 0; #1;
    n_total++;
    if (bus.irq !== 1'b0) $display("FAIL irq_disabled got=%0b exp=0", bus.irq);
    else n_pass++;
    bus.irq_en = 1;
    pop_one();
    n_total++;
    if (bus.irq !== 1'b0 || bus.count !== 5'd3)
      $display("FAIL irq_pop irq=%0b count=%0d exp 0/3", bus.irq, bus.count);
    else n_pass++;
    for (int i = 0; i < 3; i++) pop_one();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int sent = 0, recv = 0, cyc = 0, errs = 0;
    bit do_push, do_pop;
    while (recv < 40 && cyc < 3000) begin
      if (bus.rd_valid !== (q.size() > 0) ||
          bus.rd_data !== ((q.size() > 0) ? q[0] : 8'h00) ||
          bus.count !== 5'(q.size())) begin
        if (errs < 5)
          $display("FAIL wrap_state cyc=%0d rd_valid=%0b rd_data=%h count=%0d exp %0b/%h/%0d",
                   cyc, bus.rd_valid, bus.rd_data, bus.count, q.size() > 0,
                   (q.size() > 0) ? q[0] : 8'h00, q.size());
        errs++;
      end
      do_push = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
      do_pop  = ($urandom_range(0, 2) != 0);
      bus.s_axis_tvalid = do_push;
      bus.s_axis_tdata  = 8'(sent * 7 + 3);
      bus.rd_en         = do_pop;
      tick();
      if (do_pop && q.size() > 0) begin
        void'(q.pop_front());
        recv++;
      end
      if (do_push) begin
        q.push_back(8'(sent * 7 + 3));
        sent++;
      end
      cyc++;
    end
    bus.s_axis_tvalid = 0; bus.rd_en = 0;
    n_total++;
    if (errs != 0 || recv != 40)
      $display("FAIL wrap_order errors=%0d received=%0d exp 0/40", errs, recv);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) push_byte(8'(i + 8'h20));
    push_byte(8'hEE);
    for (int i = 0; i < 11; i++) pop_one();
    n_total++;
    if (bus.overrun !== 1'b1 || bus.count !== 5'd5 || bus.rd_data !== 8'h2B)
      $display("FAIL flush_setup overrun=%0b count=%0d head=%h exp 1/5/2b",
               bus.overrun, bus.count, bus.rd_data);
    else n_pass++;
    bus.flush = 1; bus.s_axis_tvalid = 1; bus.s_axis_tdata = 8'h99; bus.rd_en = 1;
    #1;
    n_total++;
    if (bus.s_axis_tready !== 1'b0) $display("FAIL flush_tready got=%0b exp=0", bus.s_axis_tready);
    else n_pass++;
    tick();
    bus.flush = 0; bus.s_axis_tvalid = 0; bus.rd_en = 0;
    n_total++;
    if (bus.count !== 5'd0 || bus.overrun !== 1'b1 || bus.rd_valid !== 1'b0)
      $display("FAIL flush count=%0d overrun=%0b rd_valid=%0b exp 0/1/0",
               bus.count, bus.overrun, bus.rd_valid);
    else n_pass++;
    bus.clr_overrun = 1; tick(); bus.clr_overrun = 0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus.clr_overrun = 1; bus.s_axis_tvalid = 1; bus.s_axis_tdata = 8'hAA;
    tick();
    bus.clr_overrun = 0; bus.s_axis_tvalid = 0;
    n_total++;
    if (bus.overrun !== 1'b1 || bus.count !== 5'd16 || bus.rd_data !== 8'h00)
      $display("FAIL set_over_clr overrun=%0b count=%0d head=%h exp 1/16/00",
               bus.overrun, bus.count, bus.rd_data);
    else n_pass++;
    bus.flush = 1; tick(); bus.flush = 0;
    pop_one();
    n_total++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.overrun !== 1'b1)
      $display("FAIL pop_empty count=%0d rd_valid=%0b rd_data=%h overrun=%0b exp 0/0/00/1",
               bus.count, bus.rd_valid, bus.rd_data, bus.overrun);
    else n_pass++;
    push_byte(8'h77);
    n_total++;
    if (bus.count !== 5'd1 || bus.rd_data !== 8'h77)
      $display("FAIL after_empty_pop count=%0d rd_data=%h exp 1/77", bus.count, bus.rd_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overrun();
    test_full_push_pop();
    test_irq();
    test_back_to_back();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
